// File: rtl/m72_pkg.sv
// Shared constants and helpers for the M72 core.
// NVRAM upload window and small byte helpers.
package m72_pkg;

  localparam logic [23:0] NVRAM_BASE = 24'h3F_0000;
  localparam logic [24:0] NVRAM_SIZE = 25'h0_4000;

  // Little-endian byte pick from a 16-bit SDRAM word.
  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/nvram_uploader.sv
// Serves hps_io upload byte reads from SDRAM through a one-word buffer.
// Requests the upload on save_req; drains a stale SDRAM request after reset.
module nvram_uploader
  import m72_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = NVRAM_BASE,
  parameter logic [24:0] SIZE      = NVRAM_SIZE
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        save_req,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        ioctl_upload_req,
  output logic [23:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_rdy,
  input  logic [15:0] sdr_dout,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitRdy, StPresent, StDrain} state_e;

  state_e      state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic        upload_req_q, upload_req_d;
  logic        upload_q;
  logic [15:0] buf_q, buf_d;
  logic [23:0] tag_q, tag_d;
  logic        valid_q, valid_d;
  logic [24:0] addr_q, addr_d;
  logic [23:0] sdr_addr_q, sdr_addr_d;
  logic        sdr_req_q, sdr_req_d;
  logic        discard_q, discard_d;

  logic upload_rise, rd_ok, out_of_range, hit, miss;

  always_comb begin
    upload_rise  = ioctl_upload & ~upload_q;
    rd_ok        = ioctl_rd & ioctl_upload & (state_q == StIdle);
    out_of_range = ioctl_addr >= SIZE;
    hit          = valid_q & ~upload_rise & (tag_q == ioctl_addr[24:1]);
    miss         = rd_ok & ~out_of_range & ~hit;
  end

  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    wait_d       = wait_q;
    upload_req_d = upload_req_q;
    buf_d        = buf_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    sdr_addr_d   = sdr_addr_q;
    sdr_req_d    = sdr_req_q;
    discard_d    = discard_q;

    // An upload that drops mid-fetch must not validate the fetched word.
    if (!ioctl_upload && (state_q == StIssue || state_q == StWaitRdy)) discard_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rd_ok) begin
          if (out_of_range) begin
            din_d = 8'hFF;
          end else if (hit) begin
            din_d = byte_sel(buf_q, ioctl_addr[0]);
          end else begin
            addr_d    = ioctl_addr;
            wait_d    = 1'b1;
            discard_d = 1'b0;
            state_d   = StIssue;
          end
        end
      end
      StIssue: begin
        sdr_addr_d = BASE_ADDR + addr_q[24:1];
        sdr_req_d  = ~sdr_req_q;
        state_d    = StWaitRdy;
      end
      StWaitRdy: begin
        if (sdr_rdy == sdr_req_q) begin
          buf_d   = sdr_dout;
          tag_d   = addr_q[24:1];
          valid_d = ~discard_q & ioctl_upload;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (!discard_q) din_d = byte_sel(buf_q, addr_q[0]);
        wait_d  = 1'b0;
        state_d = StIdle;
      end
      StDrain: begin
        if (sdr_rdy == sdr_req_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (upload_rise) begin
      upload_req_d = 1'b0;
      valid_d      = 1'b0;
    end else if (state_q == StIdle && save_req && !ioctl_upload && !upload_req_q) begin
      upload_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= (sdr_req_q != sdr_rdy) ? StDrain : StIdle;
      din_q        <= 8'h00;
      wait_q       <= 1'b0;
      upload_req_q <= 1'b0;
      upload_q     <= 1'b0;
      buf_q        <= 16'h0000;
      tag_q        <= 24'h00_0000;
      valid_q      <= 1'b0;
      addr_q       <= 25'h0;
      sdr_addr_q   <= BASE_ADDR;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      wait_q       <= wait_d;
      upload_req_q <= upload_req_d;
      upload_q     <= ioctl_upload;
      buf_q        <= buf_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      sdr_addr_q   <= sdr_addr_d;
      discard_q    <= discard_d;
    end
  end

  // The toggle handshake spans resets, so the request phase is never reset.
  always_ff @(posedge clk_sys) begin
    if (!reset) sdr_req_q <= sdr_req_d;
  end

  assign ioctl_din        = din_q;
  assign ioctl_wait       = wait_q | miss;
  assign ioctl_upload_req = upload_req_q;
  assign sdr_addr         = sdr_addr_q;
  assign sdr_req          = sdr_req_q;
  assign busy             = (state_q != StIdle);

endmodule
